instruction_decode: RTL and testbench

Decode stage of the five-stage MIPS pipeline. It consumes the IF/ID register contents (`InstrD`, `PCplus4D`) from the fetch stage and holds the 32×32 general register file. It resolves branches and jumps in D, returning `PCSrcD`/`NPCD` to fetch. It also drives the ID/EX pipeline register that feeds execute.

---
 rtl/mips_pkg.sv | 64 ++++++
 rtl/grf.sv | 37 +++
 rtl/instruction_decode.sv | 209 ++++++++++++++++++++
 tb/tb_instruction_decode.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS pipeline: opcode/funct encodings, ALU op
// codes, decode control bundle and the immediate extender.
package mips_pkg;

  localparam logic [31:0] RESET_PC = 32'h0000_3000;
  localparam logic [4:0]  REG_RA   = 5'd31;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_LUI   = 6'b001111;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;

  localparam logic [5:0] F_JR     = 6'b001000;
  localparam logic [5:0] F_ADDU   = 6'b100001;
  localparam logic [5:0] F_SUBU   = 6'b100011;

  typedef enum logic [2:0] {
    ALU_ADD = 3'b000,
    ALU_SUB = 3'b001,
    ALU_OR  = 3'b010
  } alu_op_t;

  typedef enum logic [1:0] {
    EXT_NONE = 2'd0,
    EXT_ZERO = 2'd1,
    EXT_SIGN = 2'd2,
    EXT_LUI  = 2'd3
  } ext_t;

  typedef enum logic [1:0] {
    DST_NONE = 2'd0,
    DST_RD   = 2'd1,
    DST_RT   = 2'd2,
    DST_RA   = 2'd3
  } dst_t;

  typedef struct packed {
    logic    regwrite;
    logic    memwrite;
    logic    memtoreg;
    logic    alusrc;
    logic    link;
    logic    branch;
    logic    jump;
    logic    jr;
    alu_op_t aluop;
    ext_t    ext;
    dst_t    dst;
  } ctrl_t;

  function automatic logic [31:0] extend_imm(input logic [15:0] imm, input ext_t ext);
    case (ext)
      EXT_ZERO: return {16'h0000, imm};
      EXT_SIGN: return {{16{imm[15]}}, imm};
      EXT_LUI:  return {imm, 16'h0000};
      default:  return 32'h0000_0000;
    endcase
  endfunction

endpackage

// File: rtl/grf.sv
// 32x32 general register file: two combinational reads, one write port.
// $0 is not stored and always reads zero; a read of the register being
// written this cycle returns the incoming write data.
module grf
  import mips_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic [4:0]  ra1,
  input  logic [4:0]  ra2,
  output logic [31:0] rd1,
  output logic [31:0] rd2,
  input  logic        we,
  input  logic [4:0]  wa,
  input  logic [31:0] wd
);

  logic [31:0] regs [31:1];

  // Register storage: reset clears everything and wins over a pending write.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 1; i < 32; i++) regs[i] <= 32'h0000_0000;
    end else if (we && (wa != 5'd0)) begin
      regs[wa] <= wd;
    end
  end

  // Read ports with $0 hardwired and write-through bypass.
  always_comb begin
    rd1 = 32'h0000_0000;
    rd2 = 32'h0000_0000;
    if (ra1 != 5'd0) rd1 = (we && (wa == ra1)) ? wd : regs[ra1];
    if (ra2 != 5'd0) rd2 = (we && (wa == ra2)) ? wd : regs[ra2];
  end

endmodule

// File: rtl/instruction_decode.sv
// Decode stage: instruction decoder, immediate extender, branch comparator,
// next-PC selection back to fetch, and the ID/EX pipeline register.
module instruction_decode
  import mips_pkg::*;
#(
  parameter logic [31:0] RESET_PC = mips_pkg::RESET_PC
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] InstrD,
  input  logic [31:0] PCplus4D,
  input  logic        FlushE,
  input  logic        ForwardAD,
  input  logic        ForwardBD,
  input  logic [31:0] ALUOutM,
  input  logic        RegWriteW,
  input  logic [4:0]  WriteRegW,
  input  logic [31:0] ResultW,
  output logic        PCSrcD,
  output logic [31:0] NPCD,
  output logic [4:0]  RsD,
  output logic [4:0]  RtD,
  output logic [31:0] RD1E,
  output logic [31:0] RD2E,
  output logic [31:0] ImmE,
  output logic [4:0]  RsE,
  output logic [4:0]  RtE,
  output logic [4:0]  WriteRegE,
  output logic [31:0] PC8E,
  output logic        RegWriteE,
  output logic        MemWriteE,
  output logic        MemtoRegE,
  output logic        ALUSrcE,
  output logic        LinkE,
  output logic [2:0]  ALUOpE
);

  logic [5:0]  op;
  logic [5:0]  funct;
  logic [4:0]  rs;
  logic [4:0]  rt;
  logic [4:0]  rd;
  logic [4:0]  shamt;
  logic [15:0] imm16;
  logic [25:0] index;

  assign op    = InstrD[31:26];
  assign rs    = InstrD[25:21];
  assign rt    = InstrD[20:16];
  assign rd    = InstrD[15:11];
  assign shamt = InstrD[10:6];
  assign funct = InstrD[5:0];
  assign imm16 = InstrD[15:0];
  assign index = InstrD[25:0];

  assign RsD = rs;
  assign RtD = rt;

  logic [31:0] grf_rd1;
  logic [31:0] grf_rd2;
  logic [31:0] fa;
  logic [31:0] fb;

  grf u_grf (
    .clk   (clk),
    .reset (reset),
    .ra1   (rs),
    .ra2   (rt),
    .rd1   (grf_rd1),
    .rd2   (grf_rd2),
    .we    (RegWriteW),
    .wa    (WriteRegW),
    .wd    (ResultW)
  );

  assign fa = ForwardAD ? ALUOutM : grf_rd1;
  assign fb = ForwardBD ? ALUOutM : grf_rd2;

  ctrl_t       ctrl;
  logic [31:0] imm_ext;
  logic [4:0]  dest;

  // Main decoder; anything unrecognised stays an all-zero (nop) bundle.
  always_comb begin
    ctrl = '0;
    case (op)
      OP_RTYPE: begin
        if (shamt == 5'd0) begin
          case (funct)
            F_ADDU: begin
              ctrl.regwrite = 1'b1;
              ctrl.dst      = DST_RD;
              ctrl.aluop    = ALU_ADD;
            end
            F_SUBU: begin
              ctrl.regwrite = 1'b1;
              ctrl.dst      = DST_RD;
              ctrl.aluop    = ALU_SUB;
            end
            F_JR:    ctrl.jr = 1'b1;
            default: ;
          endcase
        end
      end
      OP_ORI: begin
        ctrl.regwrite = 1'b1;
        ctrl.alusrc   = 1'b1;
        ctrl.aluop    = ALU_OR;
        ctrl.ext      = EXT_ZERO;
        ctrl.dst      = DST_RT;
      end
      OP_LUI: begin
        ctrl.regwrite = 1'b1;
        ctrl.alusrc   = 1'b1;
        ctrl.aluop    = ALU_OR;
        ctrl.ext      = EXT_LUI;
        ctrl.dst      = DST_RT;
      end
      OP_LW: begin
        ctrl.regwrite = 1'b1;
        ctrl.memtoreg = 1'b1;
        ctrl.alusrc   = 1'b1;
        ctrl.ext      = EXT_SIGN;
        ctrl.dst      = DST_RT;
      end
      OP_SW: begin
        ctrl.memwrite = 1'b1;
        ctrl.alusrc   = 1'b1;
        ctrl.ext      = EXT_SIGN;
      end
      OP_BEQ: begin
        ctrl.branch = 1'b1;
        ctrl.aluop  = ALU_SUB;
        ctrl.ext    = EXT_SIGN;
      end
      OP_J: ctrl.jump = 1'b1;
      OP_JAL: begin
        ctrl.jump     = 1'b1;
        ctrl.regwrite = 1'b1;
        ctrl.link     = 1'b1;
        ctrl.dst      = DST_RA;
      end
      default: ;
    endcase
  end

  assign imm_ext = extend_imm(imm16, ctrl.ext);

  // Destination register select; no-write instructions carry 0.
  always_comb begin
    dest = 5'd0;
    case (ctrl.dst)
      DST_RD:  dest = rd;
      DST_RT:  dest = rt;
      DST_RA:  dest = REG_RA;
      default: dest = 5'd0;
    endcase
  end

  // Branch/jump resolution and redirect target back to fetch.
  always_comb begin
    PCSrcD = 1'b0;
    NPCD   = PCplus4D;
    if (ctrl.branch && (fa == fb)) begin
      PCSrcD = 1'b1;
      NPCD   = PCplus4D + {imm_ext[29:0], 2'b00};
    end else if (ctrl.jump) begin
      PCSrcD = 1'b1;
      NPCD   = {PCplus4D[31:28], index, 2'b00};
    end else if (ctrl.jr) begin
      PCSrcD = 1'b1;
      NPCD   = fa;
    end
  end

  // ID/EX register: reset or flush loads a bubble, otherwise loads every edge.
  always_ff @(posedge clk) begin
    if (reset || FlushE) begin
      RD1E      <= 32'h0000_0000;
      RD2E      <= 32'h0000_0000;
      ImmE      <= 32'h0000_0000;
      RsE       <= 5'd0;
      RtE       <= 5'd0;
      WriteRegE <= 5'd0;
      PC8E      <= RESET_PC + 32'd8;
      RegWriteE <= 1'b0;
      MemWriteE <= 1'b0;
      MemtoRegE <= 1'b0;
      ALUSrcE   <= 1'b0;
      LinkE     <= 1'b0;
      ALUOpE    <= 3'b000;
    end else begin
      RD1E      <= fa;
      RD2E      <= fb;
      ImmE      <= imm_ext;
      RsE       <= rs;
      RtE       <= rt;
      WriteRegE <= dest;
      PC8E      <= PCplus4D + 32'd4;
      RegWriteE <= ctrl.regwrite;
      MemWriteE <= ctrl.memwrite;
      MemtoRegE <= ctrl.memtoreg;
      ALUSrcE   <= ctrl.alusrc;
      LinkE     <= ctrl.link;
      ALUOpE    <= ctrl.aluop;
    end
  end

endmodule

// File: tb/tb_instruction_decode.sv
// Scoreboard bench for the decode stage: each driven cycle pushes its
// hand-computed redirect and ID/EX expectations; the monitor pops and checks.
module tb_instruction_decode;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] InstrD;
  logic [31:0] PCplus4D;
  logic        FlushE;
  logic        ForwardAD;
  logic        ForwardBD;
  logic [31:0] ALUOutM;
  logic        RegWriteW;
  logic [4:0]  WriteRegW;
  logic [31:0] ResultW;
  logic        PCSrcD;
  logic [31:0] NPCD;
  logic [4:0]  RsD;
  logic [4:0]  RtD;
  logic [31:0] RD1E;
  logic [31:0] RD2E;
  logic [31:0] ImmE;
  logic [4:0]  RsE;
  logic [4:0]  RtE;
  logic [4:0]  WriteRegE;
  logic [31:0] PC8E;
  logic        RegWriteE;
  logic        MemWriteE;
  logic        MemtoRegE;
  logic        ALUSrcE;
  logic        LinkE;
  logic [2:0]  ALUOpE;

  instruction_decode dut (
    .clk       (clk),
    .reset     (reset),
    .InstrD    (InstrD),
    .PCplus4D  (PCplus4D),
    .FlushE    (FlushE),
    .ForwardAD (ForwardAD),
    .ForwardBD (ForwardBD),
    .ALUOutM   (ALUOutM),
    .RegWriteW (RegWriteW),
    .WriteRegW (WriteRegW),
    .ResultW   (ResultW),
    .PCSrcD    (PCSrcD),
    .NPCD      (NPCD),
    .RsD       (RsD),
    .RtD       (RtD),
    .RD1E      (RD1E),
    .RD2E      (RD2E),
    .ImmE      (ImmE),
    .RsE       (RsE),
    .RtE       (RtE),
    .WriteRegE (WriteRegE),
    .PC8E      (PC8E),
    .RegWriteE (RegWriteE),
    .MemWriteE (MemWriteE),
    .MemtoRegE (MemtoRegE),
    .ALUSrcE   (ALUSrcE),
    .LinkE     (LinkE),
    .ALUOpE    (ALUOpE)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] rd1;
    logic [31:0] rd2;
    logic [31:0] imm;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  wr;
    logic [31:0] pc8;
    logic [4:0]  ctl;   // {RegWrite, MemWrite, MemtoReg, ALUSrc, Link}
    logic [2:0]  op;
  } e_t;

  typedef struct packed {
    logic        pcsrc;
    logic [31:0] npc;
    logic [4:0]  rs;
    logic [4:0]  rt;
    e_t          e;
  } exp_t;

  exp_t sb[$];
  int   n_vec  = 0;
  int   n_fail = 0;

  function automatic e_t mk_e(input logic [31:0] rd1, rd2, imm, input logic [4:0] rs, rt, wr,
                              input logic [31:0] pc8, input logic [4:0] ctl, input logic [2:0] op);
    e_t e;
    e.rd1 = rd1; e.rd2 = rd2; e.imm = imm; e.rs = rs; e.rt = rt; e.wr = wr;
    e.pc8 = pc8; e.ctl = ctl; e.op = op;
    return e;
  endfunction

  function automatic logic [31:0] r_ins(input logic [4:0] rs, rt, rd, input logic [5:0] f);
    return {6'b000000, rs, rt, rd, 5'd0, f};
  endfunction

  function automatic logic [31:0] i_ins(input logic [5:0] op, input logic [4:0] rs, rt, input logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction

  function automatic logic [31:0] j_ins(input logic [5:0] op, input logic [25:0] idx);
    return {op, idx};
  endfunction

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // One driven cycle. ctl = {reset, FlushE, ForwardAD, ForwardBD}.
  task automatic cyc(input logic [3:0] ctl, input logic [31:0] aluout, input logic [31:0] instr,
                     input logic [31:0] pc4, input logic rw, input logic [4:0] wr, input logic [31:0] res,
                     input logic pcsrc, input logic [31:0] npc, input e_t e);
    exp_t x;
    @(negedge clk);
    {reset, FlushE, ForwardAD, ForwardBD} = ctl;
    ALUOutM = aluout; InstrD = instr; PCplus4D = pc4;
    RegWriteW = rw; WriteRegW = wr; ResultW = res;
    x.pcsrc = pcsrc; x.npc = npc; x.rs = instr[25:21]; x.rt = instr[20:16]; x.e = e;
    sb.push_back(x);
  endtask

  // Monitor: D-stage outputs checked mid-cycle, ID/EX checked after the edge.
  initial begin
    exp_t cur;
    forever begin
      @(negedge clk);
      #3;
      if (sb.size() > 0) begin
        cur = sb.pop_front();
        cmp("PCSrcD", {31'd0, PCSrcD}, {31'd0, cur.pcsrc});
        cmp("NPCD", NPCD, cur.npc);
        cmp("RsD", {27'd0, RsD}, {27'd0, cur.rs});
        cmp("RtD", {27'd0, RtD}, {27'd0, cur.rt});
        @(posedge clk);
        #1;
        cmp("RD1E", RD1E, cur.e.rd1);
        cmp("RD2E", RD2E, cur.e.rd2);
        cmp("ImmE", ImmE, cur.e.imm);
        cmp("RsE", {27'd0, RsE}, {27'd0, cur.e.rs});
        cmp("RtE", {27'd0, RtE}, {27'd0, cur.e.rt});
        cmp("WriteRegE", {27'd0, WriteRegE}, {27'd0, cur.e.wr});
        cmp("PC8E", PC8E, cur.e.pc8);
        cmp("ctlE", {27'd0, RegWriteE, MemWriteE, MemtoRegE, ALUSrcE, LinkE}, {27'd0, cur.e.ctl});
        cmp("ALUOpE", {29'd0, ALUOpE}, {29'd0, cur.e.op});
      end
    end
  end

  localparam logic [5:0] ADDU = 6'h21, SUBU = 6'h23, JR = 6'h08;
  localparam logic [5:0] OJ = 6'h02, OJAL = 6'h03, OBEQ = 6'h04, OORI = 6'h0D;
  localparam logic [5:0] OLUI = 6'h0F, OLW = 6'h23, OSW = 6'h2B, OADDI = 6'h08;

  initial begin
    e_t rst_e;
    rst_e = mk_e(0, 0, 0, 0, 0, 0, 32'h3008, 5'b00000, 3'b000);
    reset = 1'b1; FlushE = 1'b0; ForwardAD = 1'b0; ForwardBD = 1'b0; ALUOutM = 0;
    InstrD = 0; PCplus4D = 32'h3004; RegWriteW = 1'b0; WriteRegW = 0; ResultW = 0;

    // reset, then nop
    cyc(4'b1000, 0, 0, 32'h3004, 0, 0, 0, 0, 32'h3004, rst_e);
    cyc(4'b0000, 0, 0, 32'h3004, 0, 0, 0, 0, 32'h3004, mk_e(0, 0, 0, 0, 0, 0, 32'h3008, 5'b00000, 3'b000));
    // write-through of $5 into addu $3,$5,$0
    cyc(4'b0000, 0, r_ins(5, 0, 3, ADDU), 32'h3008, 1, 5, 32'h1234, 0, 32'h3008,
        mk_e(32'h1234, 0, 0, 5, 0, 3, 32'h300C, 5'b10000, 3'b000));
    // write to $0 dropped; $5 now stored
    cyc(4'b0000, 0, r_ins(0, 5, 3, ADDU), 32'h300C, 1, 0, 32'hFFFF_FFFF, 0, 32'h300C,
        mk_e(0, 32'h1234, 0, 0, 5, 3, 32'h3010, 5'b10000, 3'b000));
    // $1=7, ori $2,$0,0x8001 (zero-extend, $0 still reads 0)
    cyc(4'b0000, 0, i_ins(OORI, 0, 2, 16'h8001), 32'h3010, 1, 1, 7, 0, 32'h3010,
        mk_e(0, 0, 32'h0000_8001, 0, 2, 2, 32'h3014, 5'b10010, 3'b010));
    // $2=7, subu $7,$1,$2
    cyc(4'b0000, 0, r_ins(1, 2, 7, SUBU), 32'h3014, 1, 2, 7, 0, 32'h3014,
        mk_e(7, 7, 0, 1, 2, 7, 32'h3018, 5'b10000, 3'b001));
    // beq $1,$2,-2 taken
    cyc(4'b0000, 0, i_ins(OBEQ, 1, 2, 16'hFFFE), 32'h3010, 0, 0, 0, 1, 32'h3008,
        mk_e(7, 7, 32'hFFFF_FFFE, 1, 2, 0, 32'h3014, 5'b00000, 3'b001));
    // same beq with rt forwarded as 8: not taken
    cyc(4'b0001, 8, i_ins(OBEQ, 1, 2, 16'hFFFE), 32'h3010, 0, 0, 0, 0, 32'h3010,
        mk_e(7, 8, 32'hFFFF_FFFE, 1, 2, 0, 32'h3014, 5'b00000, 3'b001));
    // jal 0x0C00
    cyc(4'b0000, 0, j_ins(OJAL, 26'h0000C00), 32'h3004, 0, 0, 0, 1, 32'h3000,
        mk_e(0, 0, 0, 0, 0, 31, 32'h3008, 5'b10001, 3'b000));
    // $31=0x3008 written this cycle, jr $31
    cyc(4'b0000, 0, r_ins(31, 0, 0, JR), 32'h3008, 1, 31, 32'h3008, 1, 32'h3008,
        mk_e(32'h3008, 0, 0, 31, 0, 0, 32'h300C, 5'b00000, 3'b000));
    // jr $31 with rs forwarded
    cyc(4'b0010, 32'h4444, r_ins(31, 0, 0, JR), 32'h3040, 0, 0, 0, 1, 32'h4444,
        mk_e(32'h4444, 0, 0, 31, 0, 0, 32'h3044, 5'b00000, 3'b000));
    // j keeps PC upper nibble
    cyc(4'b0000, 0, j_ins(OJ, 26'h0000100), 32'h9000_0020, 0, 0, 0, 1, 32'h9000_0400,
        mk_e(0, 0, 0, 0, 0, 0, 32'h9000_0024, 5'b00000, 3'b000));
    // lw $4,-4($29) flushed, then not flushed
    cyc(4'b0100, 0, i_ins(OLW, 29, 4, 16'hFFFC), 32'h3030, 0, 0, 0, 0, 32'h3030, rst_e);
    cyc(4'b0000, 0, i_ins(OLW, 29, 4, 16'hFFFC), 32'h3030, 0, 0, 0, 0, 32'h3030,
        mk_e(0, 0, 32'hFFFF_FFFC, 29, 4, 4, 32'h3034, 5'b10110, 3'b000));
    // sw $2,8($1)
    cyc(4'b0000, 0, i_ins(OSW, 1, 2, 16'h0008), 32'h3038, 0, 0, 0, 0, 32'h3038,
        mk_e(7, 7, 32'h8, 1, 2, 0, 32'h303C, 5'b01010, 3'b000));
    // lui $9,0xABCD
    cyc(4'b0000, 0, i_ins(OLUI, 0, 9, 16'hABCD), 32'h3040, 0, 0, 0, 0, 32'h3040,
        mk_e(0, 0, 32'hABCD_0000, 0, 9, 9, 32'h3044, 5'b10010, 3'b010));
    // unsupported addi decodes as nop
    cyc(4'b0000, 0, i_ins(OADDI, 1, 2, 16'h0005), 32'h3044, 0, 0, 0, 0, 32'h3044,
        mk_e(7, 7, 0, 1, 2, 0, 32'h3048, 5'b00000, 3'b000));
    // flush with a concurrent GRF write: write lands, ID/EX bubbled
    cyc(4'b0100, 0, r_ins(10, 0, 11, ADDU), 32'h3048, 1, 10, 32'h55, 0, 32'h3048, rst_e);
    cyc(4'b0000, 0, r_ins(10, 0, 11, ADDU), 32'h3048, 0, 0, 0, 0, 32'h3048,
        mk_e(32'h55, 0, 0, 10, 0, 11, 32'h304C, 5'b10000, 3'b000));
    // beq unequal (not taken), beq equal with positive offset (taken)
    cyc(4'b0000, 0, i_ins(OBEQ, 1, 10, 16'h0003), 32'h3050, 0, 0, 0, 0, 32'h3050,
        mk_e(7, 32'h55, 3, 1, 10, 0, 32'h3054, 5'b00000, 3'b001));
    cyc(4'b0000, 0, i_ins(OBEQ, 10, 10, 16'h0003), 32'h3050, 0, 0, 0, 1, 32'h305C,
        mk_e(32'h55, 32'h55, 3, 10, 10, 0, 32'h3054, 5'b00000, 3'b001));
    // reset mid-operation discards a write and clears the GRF
    cyc(4'b1000, 0, i_ins(OLW, 29, 4, 16'hFFFC), 32'h3060, 1, 12, 9, 0, 32'h3060, rst_e);
    cyc(4'b0000, 0, r_ins(1, 12, 3, ADDU), 32'h3060, 0, 0, 0, 0, 32'h3060,
        mk_e(0, 0, 0, 1, 12, 3, 32'h3064, 5'b10000, 3'b000));

    for (int i = 0; i < 20 && sb.size() != 0; i++) @(posedge clk);
    repeat (2) @(posedge clk);
    #2;
    if (sb.size() != 0) begin
      n_vec++;
      n_fail++;
      $display("FAIL drain: %0d entries left, expected 0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
